kbd_scan_seq: RTL and testbench
===============================

KBD_SCAN_SEQ -- requirements
Module: kbd_scan_seq

Interface
REQ-001 SHALL have parameter: TIMEOUT, 1000000, idle cycles after which a pending prefix (E0/F0) is discarded; legal range 2..2^20.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  8  scan-code byte from the PS/2 receiver.
REQ-005 SHALL have port: in_valid  input  1  in_data is valid.
REQ-006 SHALL have port: in_ready  output  1  byte is accepted when in_valid && in_ready.
REQ-007 SHALL have port: key  output  8  scan code of the last decoded make/break.
REQ-008 SHALL have port: key_ext  output  1  key was E0-prefixed.
REQ-009 SHALL have port: is_press  output  1  a key is currently held.
REQ-010 SHALL have port: count  output  8  two-digit BCD count of new key presses.
REQ-011 SHALL have port: evt_valid  output  1  one-cycle key event pulse.
REQ-012 SHALL have port: evt_break  output  1  qualifies evt_valid: 1 = release, 0 = press; 0 when evt_valid=0.

Function
REQ-013 SHALL implement the FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen) and EMIT.
REQ-014 SHALL drive in_ready=1 in every state except EMIT.
REQ-015 IDLE: E0 -> EXT; F0 -> BRK; 00 or FF -> discarded, stay IDLE; any other byte -> make code with ext=0.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT; 00/FF -> IDLE, discarded; any other byte -> make code with ext=1.
REQ-017 BRK/EXT_BRK: E0, F0, 00 or FF -> IDLE, no event; any other byte -> break code with ext=0 or 1 respectively.
REQ-018 Make code that equals {key,key_ext} while is_press=1 is typematic repeat: no event, count unchanged, next state IDLE.
REQ-019 Any other make code: key<=code, key_ext<=ext, is_press<=1, count increments, evt_break<=0, next state EMIT.
REQ-020 Break code: key<=code, key_ext<=ext, evt_break<=1, next state EMIT; is_press<=0 only if code and ext equal the held key.
REQ-021 EMIT: evt_valid=1 for exactly one cycle, then IDLE; evt_valid asserts the cycle after the final byte is accepted.
REQ-022 count SHALL be BCD: low digit 9 -> 0 with carry; 99 -> 00 wrap; it never holds a non-BCD digit.
REQ-023 In EXT, BRK and EXT_BRK, a 20-bit counter SHALL count cycles without an accepted byte; on reaching TIMEOUT-1 the FSM returns to IDLE with no event.
REQ-024 The timeout counter SHALL clear on every accepted byte and in IDLE/EMIT.
REQ-025 key, key_ext, is_press and count SHALL hold their values between events.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, key=8'h00, key_ext=0, is_press=0, count=8'h00, evt_valid=0, evt_break=0, timeout counter=0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset; a byte presented while rst=1 is not consumed.
REQ-028 Reset mid-prefix or in EMIT SHALL discard the partial sequence and the pending event.

Configuration
REQ-029 Macro KBD_EXT_EN defined: E0 handling per REQ-015..REQ-020.
REQ-030 KBD_EXT_EN undefined: states EXT and EXT_BRK are absent, E0 in IDLE is discarded with no state change, and key_ext is tied to 0.

Verification
REQ-031 Reset, then bytes 1C, F0, 1C -> one press event (key=1C, count=01, is_press=1), then one break event (evt_break=1, is_press=0).
REQ-032 Bytes 1C, 1C, 1C, F0, 1C -> exactly two events, count=01.
REQ-033 With KBD_EXT_EN defined, bytes E0, 75, E0, F0, 75 -> press with key=75, key_ext=1, then break with key_ext=1 and is_press=0; with KBD_EXT_EN undefined, the same bytes give key_ext=0 throughout.
REQ-034 With TIMEOUT=16: F0, then 16 idle cycles, then 1C -> one press event only; count increments and evt_break=0.
REQ-035 Preload count=99 by 99 distinct press/release pairs, then one more press -> count=00; rst asserted after an F0 -> no event, all outputs at reset values.

Source files
------------

// File: rtl/kbd_scan_seq_if.sv
// Byte stream in (valid/ready) and decoded key state plus event pulse out for kbd_scan_seq.
interface kbd_scan_seq_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] key;
    logic       key_ext;
    logic       is_press;
    logic [7:0] count;
    logic       evt_valid;
    logic       evt_break;

    modport master (
        output in_data, in_valid,
        input  in_ready, key, key_ext, is_press, count, evt_valid, evt_break
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, key, key_ext, is_press, count, evt_valid, evt_break
    );
endinterface

// File: rtl/kbd_scan_seq.sv
// PS/2 scan-code sequencer: F0/E0 prefixed bytes -> press/release events, BCD press count (E0 decoding under KBD_EXT_EN).
// Latency: event pulse one cycle after the final byte; backpressure: in_ready low only in the EMIT cycle.
module kbd_scan_seq #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    kbd_scan_seq_if.slave bus
);

`ifdef KBD_EXT_EN
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, EMIT} state_t;
`else
    typedef enum logic [2:0] {IDLE, BRK, EMIT} state_t;
`endif

    localparam logic [19:0] TMO_LAST = 20'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  key_q, key_n;
    logic        ext_q, ext_n;
    logic        press_q, press_n;
    logic [7:0]  count_q, count_n;
    logic        brk_q, brk_n;
    logic [19:0] tmo, tmo_n;

    logic accept;
    logic junk;
    logic ctrl;
    logic in_prefix;
    logic do_make;
    logic do_break;
    logic code_ext;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = v[3:0];
        hi = v[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    always_comb begin
        state_n  = state;
        key_n    = key_q;
        ext_n    = ext_q;
        press_n  = press_q;
        count_n  = count_q;
        brk_n    = brk_q;
        tmo_n    = '0;
        do_make  = 1'b0;
        do_break = 1'b0;
        code_ext = 1'b0;

        accept = bus.in_valid && (state != EMIT);
        junk   = (bus.in_data == 8'h00) || (bus.in_data == 8'hFF);
        ctrl   = junk || (bus.in_data == 8'hE0) || (bus.in_data == 8'hF0);

        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data == 8'hF0) begin
                        state_n = BRK;
                    end else if (bus.in_data == 8'hE0) begin
`ifdef KBD_EXT_EN
                        state_n = EXT;
`endif
                    end else if (!junk) begin
                        do_make = 1'b1;
                    end
                end
            end
`ifdef KBD_EXT_EN
            EXT: begin
                if (accept) begin
                    if (bus.in_data == 8'hF0) begin
                        state_n = EXT_BRK;
                    end else if (bus.in_data == 8'hE0) begin
                        state_n = EXT;
                    end else if (junk) begin
                        state_n = IDLE;
                    end else begin
                        do_make  = 1'b1;
                        code_ext = 1'b1;
                    end
                end
            end
            EXT_BRK: begin
                if (accept) begin
                    state_n = IDLE;
                    if (!ctrl) begin
                        do_break = 1'b1;
                        code_ext = 1'b1;
                    end
                end
            end
`endif
            BRK: begin
                if (accept) begin
                    state_n = IDLE;
                    if (!ctrl) do_break = 1'b1;
                end
            end
            EMIT:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // A stalled prefix is abandoned so a lost byte cannot corrupt the next key.
`ifdef KBD_EXT_EN
        in_prefix = (state == BRK) || (state == EXT) || (state == EXT_BRK);
`else
        in_prefix = (state == BRK);
`endif
        if (in_prefix && !accept) begin
            if (tmo == TMO_LAST) state_n = IDLE;
            else                 tmo_n   = tmo + 20'd1;
        end

        if (do_make) begin
            if (press_q && (bus.in_data == key_q) && (code_ext == ext_q)) begin
                state_n = IDLE;
            end else begin
                key_n   = bus.in_data;
                ext_n   = code_ext;
                press_n = 1'b1;
                count_n = bcd_inc(count_q);
                brk_n   = 1'b0;
                state_n = EMIT;
            end
        end

        if (do_break) begin
            if ((bus.in_data == key_q) && (code_ext == ext_q)) press_n = 1'b0;
            key_n   = bus.in_data;
            ext_n   = code_ext;
            brk_n   = 1'b1;
            state_n = EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_q   <= 8'h00;
            ext_q   <= 1'b0;
            press_q <= 1'b0;
            count_q <= 8'h00;
            brk_q   <= 1'b0;
            tmo     <= '0;
        end else begin
            state   <= state_n;
            key_q   <= key_n;
            ext_q   <= ext_n;
            press_q <= press_n;
            count_q <= count_n;
            brk_q   <= brk_n;
            tmo     <= tmo_n;
        end
    end

    assign bus.in_ready  = (state != EMIT);
    assign bus.key       = key_q;
`ifdef KBD_EXT_EN
    assign bus.key_ext   = ext_q;
`else
    assign bus.key_ext   = 1'b0;
`endif
    assign bus.is_press  = press_q;
    assign bus.count     = count_q;
    assign bus.evt_valid = (state == EMIT);
    assign bus.evt_break = brk_q && (state == EMIT);

endmodule

// File: tb/tb_kbd_scan_seq.sv
// Bench for kbd_scan_seq: table of bytes with expected events fed to a scoreboard, plus timeout, reset and BCD-wrap sequences.
module tb_kbd_scan_seq;
    localparam int unsigned TMO = 16;
`ifdef KBD_EXT_EN
    localparam logic X = 1'b1;
`else
    localparam logic X = 1'b0;
`endif

    typedef struct {
        logic [7:0] key;
        logic       ext;
        logic       brk;
        logic       press;
        logic [7:0] count;
        int         cyc;
    } evt_t;

    typedef struct {
        logic [7:0] b;
        bit         ev;
        logic [7:0] key;
        logic       ext;
        logic       brk;
        logic       press;
        logic [7:0] count;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    evt_t sb[$];
    vec_t vecs[$];
    evt_t mon_e;

    kbd_scan_seq_if bus ();

    kbd_scan_seq #(.TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic void add(input logic [7:0] b, input bit ev, input logic [7:0] key,
                                input logic ext, input logic brk, input logic press,
                                input logic [7:0] count);
        vec_t v;
        v = '{b, ev, key, ext, brk, press, count};
        vecs.push_back(v);
    endfunction

    // Drive one byte, wait for acceptance, and queue the event it should produce.
    task automatic send(input logic [7:0] b, input bit ev, input logic [7:0] key,
                        input logic ext, input logic brk, input logic press,
                        input logic [7:0] count);
        int   n;
        evt_t e;
        n = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: byte %0h not accepted in_ready=%0b required 1", b, bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (ev) begin
                e = '{key, ext, brk, press, count, cyc};
                sb.push_back(e);
            end
        end
    endtask

    task automatic send_nv(input logic [7:0] b);
        send(b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_key"},       bus.key,       8'h00);
        chk({tag, "_key_ext"},   bus.key_ext,   1'b0);
        chk({tag, "_is_press"},  bus.is_press,  1'b0);
        chk({tag, "_count"},     bus.count,     8'h00);
        chk({tag, "_evt_valid"}, bus.evt_valid, 1'b0);
        chk({tag, "_evt_break"}, bus.evt_break, 1'b0);
    endtask

    always @(negedge clk) begin
        if (bus.evt_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: key=%0h break=%0b count=%0h, none required", bus.key, bus.evt_break, bus.count);
            end else begin
                mon_e = sb.pop_front();
                chk("evt_key",      bus.key,       mon_e.key);
                chk("evt_key_ext",  bus.key_ext,   mon_e.ext);
                chk("evt_break",    bus.evt_break, mon_e.brk);
                chk("evt_is_press", bus.is_press,  mon_e.press);
                chk("evt_count",    bus.count,     mon_e.count);
                chk("evt_cycle",    cyc,           mon_e.cyc);
                chk("evt_in_ready", bus.in_ready,  1'b0);
            end
        end else begin
            chk("evt_break_idle", bus.evt_break, 1'b0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_data  = 8'h1C;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_count",    bus.count,    8'h00);

        //   byte   ev    key    ext   brk   press count
        add(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h01);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h01);
        add(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h02);
        add(8'h1C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h1C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h02);
        add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h03);
        add(8'h32, 1'b1, 8'h32, 1'b0, 1'b0, 1'b1, 8'h04);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h32, 1'b1, 8'h32, 1'b0, 1'b1, 1'b0, 8'h04);
        add(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b1, 8'h75, X,    1'b0, 1'b1, 8'h05);
        add(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b1, 8'h75, X,    1'b1, 1'b0, 8'h05);
        add(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b1, 8'h75, X,    1'b0, 1'b1, 8'h06);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hE0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(8'h75, 1'b1, 8'h75, X,    1'b1, 1'b0, 8'h06);

        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].b, vecs[i].ev, vecs[i].key, vecs[i].ext,
                 vecs[i].brk, vecs[i].press, vecs[i].count);
        end
        repeat (2) @(negedge clk);
        chk("table_drained", sb.size(), 0);

        // Prefix timeout: one cycle short still decodes a break, full length drops the F0.
        send_nv(8'hF0);
        repeat (TMO - 1) @(posedge clk);
        send(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h06);
        send_nv(8'hF0);
        repeat (TMO) @(posedge clk);
        send(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h07);
        send_nv(8'hF0);
        send(8'h1C, 1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 8'h07);
        repeat (2) @(negedge clk);
        chk("timeout_drained", sb.size(), 0);

        // Reset with a pending F0: partial sequence discarded.
        send(8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h08);
        send_nv(8'hF0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        send(8'h33, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h01);

        // 99 press/release pairs, then one more press wraps the BCD count.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 99; i++) begin
            send(8'(i + 1), 1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b1, bcd(i + 1));
            send_nv(8'hF0);
            send(8'(i + 1), 1'b1, 8'(i + 1), 1'b0, 1'b1, 1'b0, bcd(i + 1));
        end
        @(negedge clk);
        chk("preload_count", bus.count, 8'h99);
        send(8'h70, 1'b1, 8'h70, 1'b0, 1'b0, 1'b1, 8'h00);
        repeat (2) @(negedge clk);
        chk("wrap_count", bus.count, 8'h00);
        chk("wrap_is_press", bus.is_press, 1'b1);
        chk("final_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
